// File: rtl/gpio_apb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gpio_apb_arbiter_pkg
//   Shared definitions for the GPIO expander APB path: FSM state encodings,
//   bank index width, default watchdog limit and APB width defaults reused by
//   the bank slaves and the SPI bridge.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package gpio_apb_arbiter_pkg;

    // APB master FSM encodings.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Width of the bank index carried by every requester.
    localparam int BANK_IDX_W = 3;

    // Defaults shared with the bank slave and the bridge.
    localparam int DEFAULT_BANK_NUM = 2;
    localparam int DEFAULT_PADDR_W  = 3;
    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_TIMEOUT  = 16;

    // True when the requested bank exists on this bus.
    function automatic logic bank_in_range(input logic [BANK_IDX_W-1:0] bank,
                                           input int bank_num);
        return int'(bank) < bank_num;
    endfunction

endpackage

// File: rtl/gpio_rr_arb2.sv
// -----------------------------------------------------------------------------
// gpio_rr_arb2
//   Two-way round-robin arbiter (purely combinational).
//   Ports:
//     req_i        [1:0]  raw requests
//     mask_i       [1:0]  requesters excluded this cycle
//     last_grant_i        index of the previously granted requester
//     grant_o             index of the winner (valid only with valid_o)
//     valid_o             at least one requester is eligible
// -----------------------------------------------------------------------------
module gpio_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    logic [1:0] eligible;

    assign eligible = req_i & ~mask_i;
    assign valid_o  = |eligible;
    // On a tie the requester that did not win last time gets the bus.
    assign grant_o  = (&eligible) ? ~last_grant_i : eligible[1];

endmodule

// File: rtl/gpio_apb_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_apb_arbiter
//   Shares the expander's single APB bus to the GPIO banks between the SPI
//   command path (req0) and the input-scan/IRQ engine (req1). Round-robin
//   arbitration, APB SETUP/ACCESS sequencing, one-hot bank select, pready
//   watchdog and bank-range checking. All outputs are registered.
//   Ports:
//     pclk, presetn                 clock / async active-low reset
//     req*, wr*, bank*, addr*, wdata*  per-requester command (held until done)
//     done*, err*, rdata*           per-requester completion return path
//     psel, penable, pwrite, paddr, pwdata   APB master outputs
//     pready, prdata                muxed APB slave response
// -----------------------------------------------------------------------------
module gpio_apb_arbiter
    import gpio_apb_arbiter_pkg::*;
#(
    parameter int BANK_NUM    = DEFAULT_BANK_NUM,
    parameter int PADDR_WIDTH = DEFAULT_PADDR_W,
    parameter int DATA_WIDTH  = DEFAULT_DATA_W,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   req0,
    input  logic                   wr0,
    input  logic [BANK_IDX_W-1:0]  bank0,
    input  logic [PADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0]  wdata0,
    output logic                   done0,
    output logic                   err0,
    output logic [DATA_WIDTH-1:0]  rdata0,
    input  logic                   req1,
    input  logic                   wr1,
    input  logic [BANK_IDX_W-1:0]  bank1,
    input  logic [PADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]  wdata1,
    output logic                   done1,
    output logic                   err1,
    output logic [DATA_WIDTH-1:0]  rdata1,
    output logic [BANK_NUM-1:0]    psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [PADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0]  pwdata,
    input  logic                   pready,
    input  logic [DATA_WIDTH-1:0]  prdata
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    logic [1:0]             state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   grant_q, grant_d;
    logic [BANK_NUM-1:0]    psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [WDOG_W-1:0]      wdog_q, wdog_d;
    logic [1:0]             done_q, done_d;
    logic [1:0]             err_q, err_d;
    logic [DATA_WIDTH-1:0]  rdata_q [2];
    logic [DATA_WIDTH-1:0]  rdata_d [2];

    logic                   arb_grant, arb_valid;
    logic                   sel_wr;
    logic [BANK_IDX_W-1:0]  sel_bank;
    logic [PADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

    // A requester whose done is showing this cycle is masked so it cannot
    // re-win the bus before it has seen completion and dropped req.
    gpio_rr_arb2 u_arb (
        .req_i        ({req1, req0}),
        .mask_i       (done_q),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    assign sel_wr    = arb_grant ? wr1    : wr0;
    assign sel_bank  = arb_grant ? bank1  : bank0;
    assign sel_addr  = arb_grant ? addr1  : addr0;
    assign sel_wdata = arb_grant ? wdata1 : wdata0;

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        wdog_d       = wdog_q;
        done_d       = 2'b00;
        err_d        = 2'b00;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    last_grant_d = arb_grant;
                    grant_d      = arb_grant;
                    if (!bank_in_range(sel_bank, BANK_NUM)) begin
                        // Nonexistent bank: answer with an error, bus untouched.
                        done_d[arb_grant]  = 1'b1;
                        err_d[arb_grant]   = 1'b1;
                        rdata_d[arb_grant] = '0;
                    end else begin
                        pwrite_d = sel_wr;
                        paddr_d  = sel_addr;
                        pwdata_d = sel_wdata;
                        psel_d   = BANK_NUM'(1) << sel_bank;
                        state_d  = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                wdog_d    = WDOG_W'(1);
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    if (!pwrite_q) begin
                        rdata_d[grant_q] = prdata;
                    end
                    done_d[grant_q] = 1'b1;
                    psel_d          = '0;
                    penable_d       = 1'b0;
                    state_d         = ST_IDLE;
                end else if (wdog_q == WDOG_W'(TIMEOUT)) begin
                    // Slave never answered: release the bus and report failure.
                    done_d[grant_q]  = 1'b1;
                    err_d[grant_q]   = 1'b1;
                    rdata_d[grant_q] = '0;
                    psel_d           = '0;
                    penable_d        = 1'b0;
                    state_d          = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;  // req0 wins the first tie
            grant_q      <= 1'b0;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            wdog_q       <= '0;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            wdog_q       <= wdog_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q[0]   <= rdata_d[0];
            rdata_q[1]   <= rdata_d[1];
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign done0   = done_q[0];
    assign done1   = done_q[1];
    assign err0    = err_q[0];
    assign err1    = err_q[1];
    assign rdata0  = rdata_q[0];
    assign rdata1  = rdata_q[1];

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpio_apb_arbiter
//   Directed bench for gpio_apb_arbiter (BANK_NUM=2, TIMEOUT=16). Inputs are
//   driven and outputs sampled on the falling edge of pclk.
// -----------------------------------------------------------------------------
module tb_gpio_apb_arbiter;

    logic       pclk;
    logic       presetn;
    logic       req0, req1, wr0, wr1;
    logic [2:0] bank0, bank1, addr0, addr1;
    logic [7:0] wdata0, wdata1, rdata0, rdata1;
    logic       done0, done1, err0, err1;
    logic [1:0] psel;
    logic       penable, pwrite, pready;
    logic [2:0] paddr;
    logic [7:0] pwdata, prdata;

    int checks = 0;
    int errors = 0;

    gpio_apb_arbiter #(
        .BANK_NUM    (2),
        .PADDR_WIDTH (3),
        .DATA_WIDTH  (8),
        .TIMEOUT     (16)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .req0    (req0),
        .wr0     (wr0),
        .bank0   (bank0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .done0   (done0),
        .err0    (err0),
        .rdata0  (rdata0),
        .req1    (req1),
        .wr1     (wr1),
        .bank1   (bank1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .done1   (done1),
        .err1    (err1),
        .rdata1  (rdata1),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pready  (pready),
        .prdata  (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200us");
        $fatal(1);
    end

    task automatic test_reset();
        presetn = 1'b0;
        repeat (2) @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite, done0, done1, err0, err1} !== 8'h00 ||
            paddr !== 3'd0 || pwdata !== 8'h00 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b done=%b%b err=%b%b paddr=%0d pwdata=%h rdata=%h/%h, required all 0",
                     psel, penable, pwrite, done1, done0, err1, err0, paddr, pwdata, rdata1, rdata0);
        end
        presetn = 1'b1;
        @(negedge pclk);
        checks++;
        if (psel !== 2'b00 || done0 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: psel=%b done=%b%b, required 00 00", psel, done1, done0);
        end
    endtask

    // T1: zero-wait write, plus masking of a requester still holding req at done.
    task automatic test_write_zero_wait();
        pready = 1'b1;
        req0 = 1'b1; wr0 = 1'b1; bank0 = 3'd0; addr0 = 3'd3; wdata0 = 8'hA5;
        @(negedge pclk);
        checks++;
        if (psel !== 2'b01 || penable !== 1'b0 || pwrite !== 1'b1 || paddr !== 3'd3 || pwdata !== 8'hA5) begin
            errors++;
            $display("FAIL t1_setup: psel=%b pen=%b pwr=%b paddr=%0d pwdata=%h, required 01 0 1 3 a5",
                     psel, penable, pwrite, paddr, pwdata);
        end
        @(negedge pclk);
        checks++;
        if (psel !== 2'b01 || penable !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL t1_access: psel=%b pen=%b done0=%b, required 01 1 0", psel, penable, done0);
        end
        @(negedge pclk);
        checks++;
        if (done0 !== 1'b1 || err0 !== 1'b0 || done1 !== 1'b0 || psel !== 2'b00 || penable !== 1'b0) begin
            errors++;
            $display("FAIL t1_done: done0=%b err0=%b done1=%b psel=%b pen=%b, required 1 0 0 00 0",
                     done0, err0, done1, psel, penable);
        end
        // req0 is still high during its done cycle; it must not be re-granted.
        @(negedge pclk);
        checks++;
        if (psel !== 2'b00 || done0 !== 1'b0 || paddr !== 3'd3 || pwdata !== 8'hA5) begin
            errors++;
            $display("FAIL t1_mask_hold: psel=%b done0=%b paddr=%0d pwdata=%h, required 00 0 3 a5",
                     psel, done0, paddr, pwdata);
        end
        req0 = 1'b0;
        @(negedge pclk);
    endtask

    // T2: read with two wait states.
    task automatic test_read_wait();
        pready = 1'b0; prdata = 8'h00;
        req1 = 1'b1; wr1 = 1'b0; bank1 = 3'd1; addr1 = 3'd2; wdata1 = 8'hFF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge pclk);
            checks++;
            if (psel !== 2'b10 || penable !== (c >= 2) || done1 !== 1'b0) begin
                errors++;
                $display("FAIL t2_bus_c%0d: psel=%b pen=%b done1=%b, required 10 %0d 0",
                         c, psel, penable, done1, (c >= 2));
            end
            if (c == 1) begin
                checks++;
                if (pwrite !== 1'b0 || paddr !== 3'd2) begin
                    errors++;
                    $display("FAIL t2_setup_fields: pwrite=%b paddr=%0d, required 0 2", pwrite, paddr);
                end
            end
            if (c == 4) begin
                pready = 1'b1; prdata = 8'h3C;
            end
        end
        @(negedge pclk);
        checks++;
        if (done1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== 8'h3C || done0 !== 1'b0 || psel !== 2'b00) begin
            errors++;
            $display("FAIL t2_done: done1=%b err1=%b rdata1=%h done0=%b psel=%b, required 1 0 3c 0 00",
                     done1, err1, rdata1, done0, psel);
        end
        req1 = 1'b0; prdata = 8'h00;
        @(negedge pclk);
        checks++;
        if (rdata1 !== 8'h3C || done1 !== 1'b0) begin
            errors++;
            $display("FAIL t2_rdata_hold: rdata1=%h done1=%b, required 3c 0", rdata1, done1);
        end
    endtask

    // T3: simultaneous held requests alternate 0,1,0,1 with a done every 3 cycles.
    task automatic test_back_to_back();
        int seq [4];
        int when [4];
        int n = 0;
        bit both_seen = 0;
        pready = 1'b1; prdata = 8'h5A;
        req0 = 1'b1; wr0 = 1'b0; bank0 = 3'd0; addr0 = 3'd1;
        req1 = 1'b1; wr1 = 1'b0; bank1 = 3'd1; addr1 = 3'd4;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge pclk);
            if (done0 && done1) both_seen = 1;
            if (done0 || done1) begin
                seq[n]  = done1 ? 1 : 0;
                when[n] = c;
                checks++;
                if ((done1 ? rdata1 : rdata0) !== 8'h5A) begin
                    errors++;
                    $display("FAIL t3_rdata_%0d: got %h, required 5a", n, done1 ? rdata1 : rdata0);
                end
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (n != 4 || both_seen) begin
            errors++;
            $display("FAIL t3_count: dones=%0d both_same_cycle=%0d, required 4 0", n, both_seen);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (seq[i] != (i % 2) || when[i] != 3 * (i + 1)) begin
                errors++;
                $display("FAIL t3_order_%0d: requester=%0d cycle=%0d, required %0d %0d",
                         i, seq[i], when[i], i % 2, 3 * (i + 1));
            end
        end
        @(negedge pclk);
        checks++;
        if (psel !== 2'b00) begin
            errors++;
            $display("FAIL t3_idle_after: psel=%b, required 00", psel);
        end
    endtask

    // T4: pready stuck low -> watchdog abort after 16 ACCESS cycles.
    task automatic test_timeout();
        int pen_cnt = 0;
        bit seen = 0;
        pready = 1'b0;
        req0 = 1'b1; wr0 = 1'b0; bank0 = 3'd1; addr0 = 3'd0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge pclk);
            if (done0) seen = 1;
            else if (penable) pen_cnt++;
        end
        checks++;
        if (!seen || pen_cnt != 16) begin
            errors++;
            $display("FAIL t4_wdog: done_seen=%0d penable_cycles=%0d, required 1 16", seen, pen_cnt);
        end
        checks++;
        if (err0 !== 1'b1 || rdata0 !== 8'h00 || psel !== 2'b00 || penable !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL t4_abort: err0=%b rdata0=%h psel=%b pen=%b done1=%b, required 1 00 00 0 0",
                     err0, rdata0, psel, penable, done1);
        end
        req0 = 1'b0; pready = 1'b1;
        @(negedge pclk);
    endtask

    // T5: out-of-range bank -> immediate error, no bus activity.
    task automatic test_bad_bank();
        req0 = 1'b1; wr0 = 1'b1; bank0 = 3'd5; addr0 = 3'd7; wdata0 = 8'h77;
        @(negedge pclk);
        checks++;
        if (done0 !== 1'b1 || err0 !== 1'b1 || psel !== 2'b00 || penable !== 1'b0 || rdata0 !== 8'h00) begin
            errors++;
            $display("FAIL t5_bad_bank: done0=%b err0=%b psel=%b pen=%b rdata0=%h, required 1 1 00 0 00",
                     done0, err0, psel, penable, rdata0);
        end
        req0 = 1'b0;
        @(negedge pclk);
        checks++;
        if (psel !== 2'b00 || done0 !== 1'b0 || err0 !== 1'b0 || paddr !== 3'd0) begin
            errors++;
            $display("FAIL t5_after: psel=%b done0=%b err0=%b paddr=%0d, required 00 0 0 0",
                     psel, done0, err0, paddr);
        end
    endtask

    // T6: reset during ACCESS, then req0 wins the first tie again.
    task automatic test_reset_mid_transfer();
        pready = 1'b0;
        req0 = 1'b1; wr0 = 1'b0; bank0 = 3'd0; addr0 = 3'd5;
        repeat (2) @(negedge pclk);
        checks++;
        if (psel !== 2'b01 || penable !== 1'b1) begin
            errors++;
            $display("FAIL t6_in_access: psel=%b pen=%b, required 01 1", psel, penable);
        end
        #2 presetn = 1'b0;
        #1;
        checks++;
        if (psel !== 2'b00 || penable !== 1'b0) begin
            errors++;
            $display("FAIL t6_async_drop: psel=%b pen=%b, required 00 0", psel, penable);
        end
        req0 = 1'b0;
        @(negedge pclk);
        checks++;
        if (done0 !== 1'b0 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL t6_no_done: done0=%b err0=%b, required 0 0", done0, err0);
        end
        presetn = 1'b1;
        @(negedge pclk);
        pready = 1'b1;
        req0 = 1'b1; wr0 = 1'b1; bank0 = 3'd0; addr0 = 3'd2; wdata0 = 8'h11;
        req1 = 1'b1; wr1 = 1'b1; bank1 = 3'd1; addr1 = 3'd6; wdata1 = 8'h22;
        @(negedge pclk);
        checks++;
        if (psel !== 2'b01 || pwdata !== 8'h11) begin
            errors++;
            $display("FAIL t6_first_grant: psel=%b pwdata=%h, required 01 11", psel, pwdata);
        end
        repeat (2) @(negedge pclk);
        checks++;
        if (done0 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL t6_done0: done0=%b done1=%b, required 1 0", done0, done1);
        end
        req0 = 1'b0;
        repeat (3) @(negedge pclk);
        checks++;
        if (done1 !== 1'b1 || err1 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL t6_done1: done1=%b err1=%b done0=%b, required 1 0 0", done1, err1, done0);
        end
        req1 = 1'b0;
        @(negedge pclk);
    endtask

    initial begin
        presetn = 1'b0;
        req0 = 1'b0; wr0 = 1'b0; bank0 = 3'd0; addr0 = 3'd0; wdata0 = 8'h00;
        req1 = 1'b0; wr1 = 1'b0; bank1 = 3'd0; addr1 = 3'd0; wdata1 = 8'h00;
        pready = 1'b0; prdata = 8'h00;

        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_bad_bank();
        test_reset_mid_transfer();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
